// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V fetch stage: pc, imem handshake, instruction register, field slices (optional FETCH_PERF_EN counters)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    output logic [31:0] pc,
    output logic [6:0]  opCode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount
`endif
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] HOLD  = 2'b10;

    logic [1:0] state;
    logic       accept;
    logic       redirect;

    // A redirect only counts once the stage is running; it overrides any accept.
    assign redirect = branchTaken && (state != IDLE);
    assign accept   = (state == FETCH) && imemReady && !branchTaken;

    // Main fetch state: FSM, pc and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr      <= NOP_INSTR;
            instrPc    <= RESET_PC;
            instrValid <= 1'b0;
        end else if (state == IDLE) begin
            state <= FETCH;
        end else if (redirect) begin
            pc         <= {branchTarget[31:2], 2'b00};
            instr      <= NOP_INSTR;
            instrValid <= 1'b0;
            state      <= FETCH;
        end else if (state == FETCH) begin
            if (imemReady) begin
                instr      <= imemData;
                instrPc    <= pc;
                instrValid <= 1'b1;
                pc         <= pc + 32'd4;
                state      <= stall ? HOLD : FETCH;
            end else if (!stall) begin
                instrValid <= 1'b0;
            end
        end else begin
            if (!stall) begin
                state      <= FETCH;
                instrValid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: accepted fetches and cycles spent holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchCount <= 32'd0;
            stallCount <= 32'd0;
        end else begin
            if (accept) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (state == HOLD) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign imemReq  = (state == FETCH);
    assign imemAddr = pc;

    assign opCode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;
    logic [31:0] pc;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
        .instr(instr), .instrPc(instrPc), .instrValid(instrValid), .pc(pc),
        .opCode(opCode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2)
`ifdef FETCH_PERF_EN
        , .fetchCount(fetchCount), .stallCount(stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: "running" says the stage has left reset idle,
    // "holding" says a stalled consumer owns the current instruction.
    bit          running;
    bit          holding;
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid;
    logic [31:0] m_fetches, m_stalls;

    task automatic model_reset();
        running = 0; holding = 0;
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 0;
        m_fetches = 0; m_stalls = 0;
    endtask

    task automatic model_edge(input bit s, input bit b, input bit r,
                              input logic [31:0] t, input logic [31:0] d);
        if (holding) m_stalls = m_stalls + 1;
        if (!running) begin
            running = 1;
        end else if (b) begin
            m_pc = t & ~32'h3; m_instr = NOP; m_valid = 0; holding = 0;
        end else if (holding) begin
            if (!s) begin holding = 0; m_valid = 0; end
        end else if (r) begin
            m_instr = d; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            m_fetches = m_fetches + 1;
            holding = s;
        end else if (!s) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("imemReq", 32'(imemReq), 32'(running && !holding));
        check("imemAddr", imemAddr, m_pc);
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("instrValid", 32'(instrValid), 32'(m_valid));
        if (m_valid) check("instrPc", instrPc, m_ipc);
        check("fields", {funct7, rs2, rs1, funct3, rd, opCode}, m_instr);
`ifdef FETCH_PERF_EN
        check("fetchCount", fetchCount, m_fetches);
        check("stallCount", stallCount, m_stalls);
`endif
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic step(input bit s, input bit b, input bit r, input logic [31:0] t);
        stall = s; branchTaken = b; imemReady = r; branchTarget = t;
        imemData = $urandom;
        @(posedge clk);
        model_edge(s, b, r, t, imemData);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; branchTaken = 0; branchTarget = 0;
        imemReady = 0; imemData = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        check("rst_opCode", 32'(opCode), 32'h13);
        rst_n = 1'b1;

        // streaming fetch: addresses 0,4,8,C
        step(0, 0, 1, 0);
        check("first_req", 32'(imemReq), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imemAddr, 32'(i * 4));
            step(0, 0, 1, 0);
        end
        check("seq_ipc", instrPc, 32'hC);

        // stall three cycles after an accept
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check("hold_req", 32'(imemReq), 32'h0);
        step(0, 0, 1, 0);

        // redirect coincident with an accept
        step(0, 1, 1, 32'h103);
        check("redir_addr", imemAddr, 32'h100);
        check("redir_instr", instr, NOP);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) < 7, t);
        end

        // wrap from the top of the address space
        step(0, 1, 1, 32'hFFFF_FFFF);
        check("wrap_top", imemAddr, 32'hFFFF_FFFC);
        step(0, 0, 1, 0);
        check("wrap_zero", imemAddr, 32'h0);
        check("wrap_ipc", instrPc, 32'hFFFF_FFFC);

        // asynchronous reset in the middle of a pending handshake
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("pend_req", 32'(imemReq), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("rst_rereq", 32'(imemReq), 32'h1);
        check("rst_readdr", imemAddr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
